sdram_bram_responder: RTL and testbench



---
 rtl/sdram_bram_responder_if.sv | 39 +++
 rtl/sdram_bram_responder.sv | 150 +++++++++++++++
 tb/tb_sdram_bram_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bram_responder_if.sv
// ---------------------------------------------------------------------------
// sdram_bram_responder_if
// Command/response bus between the SDRAM arbiter (master) and the SDRAM
// responder (slave).
//   sdram_req         master id of the pending command, 0 = none, held until ack
//   sdram_addr        byte address (bits [1:0] ignored)
//   sdram_write       1 = write, 0 = read
//   sdram_burst       1 = burst read, 0 = single beat
//   sdram_byte_enable write byte lanes, bit n covers wdata[8n+7:8n]
//   sdram_wdata       write data
//   sdram_ack         one-cycle pulse: command accepted
//   sdram_rdata       read data, 0 whenever sdram_rdvalid = 0
//   sdram_rdvalid     id of the master owning sdram_rdata, 0 = no data
//   sdram_complete    high on the final read beat only
// ---------------------------------------------------------------------------
interface sdram_bram_responder_if;
  logic [2:0]  sdram_req;
  logic [25:0] sdram_addr;
  logic        sdram_write;
  logic        sdram_burst;
  logic [3:0]  sdram_byte_enable;
  logic [31:0] sdram_wdata;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic [2:0]  sdram_rdvalid;
  logic        sdram_complete;

  modport master (
    output sdram_req, sdram_addr, sdram_write, sdram_burst,
           sdram_byte_enable, sdram_wdata,
    input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );

  modport slave (
    input  sdram_req, sdram_addr, sdram_write, sdram_burst,
           sdram_byte_enable, sdram_wdata,
    output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );
endinterface

// File: rtl/sdram_bram_responder.sv
// ---------------------------------------------------------------------------
// sdram_bram_responder
// Block-RAM backed stand-in for the SDRAM controller behind the four-master
// arbiter. Accepts one tagged command at a time, acks it, commits writes per
// byte lane, and streams read data (single beat or wrapping burst, critical
// word first) tagged with the requesting id.
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    sdram_bram_responder_if.slave command/response bus
// ---------------------------------------------------------------------------
module sdram_bram_responder #(
  parameter int    ADDR_BITS    = 14,
  parameter int    BURST_LEN    = 8,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic clock,
  input  logic reset,
  sdram_bram_responder_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_BITS-1:0] WRAP_MASK = ADDR_BITS'(BURST_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT, ST_BEAT} state_t;

  state_t                state_q;
  logic [2:0]            id_q;
  logic [ADDR_BITS-1:0]  word_q;
  logic                  write_q;
  logic                  burst_q;
  logic [BEAT_W-1:0]     beat_q;      // number of beats already sent to the RAM
  logic [WAIT_W-1:0]     wait_q;
  logic                  ack_q;
  logic [2:0]            rdvalid_q;
  logic                  complete_q;
  logic [31:0]           rd_data_q;

  logic [31:0] mem [DEPTH];

  logic                 cmd_seen;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] cmd_word;
  logic [BEAT_W-1:0]    n_beats;
  logic                 issue;
  logic                 last_issue;
  logic [ADDR_BITS-1:0] rd_addr_d;

  assign cmd_seen   = (state_q == ST_IDLE) && (bus.sdram_req != 3'd0);
  assign wr_en      = !reset && cmd_seen && bus.sdram_write;
  assign cmd_word   = bus.sdram_addr[ADDR_BITS+1:2];
  assign n_beats    = burst_q ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
  assign last_issue = (beat_q == n_beats - BEAT_W'(1));

  // Address bits outside the word index alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.sdram_addr[1:0], bus.sdram_addr[25:ADDR_BITS+2]};

  // The RAM read is issued one cycle ahead of the beat it feeds, so the
  // registered RAM output lines up with the registered rdvalid/complete.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      ST_ACK:  issue = !write_q && (READ_LATENCY == 1);
      ST_WAIT: issue = (wait_q == '0);
      ST_BEAT: issue = (beat_q != n_beats);
      default: issue = 1'b0;
    endcase
  end

  // Wrap inside the BURST_LEN-aligned block; beat_q is 0 for single reads.
  assign rd_addr_d = (word_q & ~WRAP_MASK) | ((word_q + ADDR_BITS'(beat_q)) & WRAP_MASK);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sdram_byte_enable[b]) mem[cmd_word][8*b +: 8] <= bus.sdram_wdata[8*b +: 8];
      end
    end
    rd_data_q <= mem[rd_addr_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      id_q       <= 3'd0;
      word_q     <= '0;
      write_q    <= 1'b0;
      burst_q    <= 1'b0;
      beat_q     <= '0;
      wait_q     <= '0;
      ack_q      <= 1'b0;
      rdvalid_q  <= 3'd0;
      complete_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (issue) begin
        rdvalid_q  <= id_q;
        complete_q <= last_issue;
        beat_q     <= beat_q + BEAT_W'(1);
      end else begin
        rdvalid_q  <= 3'd0;
        complete_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_seen) begin
            id_q    <= bus.sdram_req;
            word_q  <= cmd_word;
            write_q <= bus.sdram_write;
            burst_q <= bus.sdram_burst;
            beat_q  <= '0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          // The arbiter still shows this command now; it is not re-examined.
          assert (bus.sdram_req != 3'd0)
            else $error("sdram_bram_responder: ACK entered with sdram_req = 0");
          if (write_q) begin
            state_q <= ST_IDLE;
          end else if (READ_LATENCY == 1) begin
            state_q <= ST_BEAT;
          end else begin
            wait_q  <= WAIT_W'(READ_LATENCY - 2);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_q == '0) state_q <= ST_BEAT;
          else              wait_q  <= wait_q - WAIT_W'(1);
        end
        ST_BEAT: begin
          if (!issue) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sdram_ack      = ack_q;
  assign bus.sdram_rdvalid  = rdvalid_q;
  assign bus.sdram_complete = complete_q;
  assign bus.sdram_rdata    = (rdvalid_q != 3'd0) ? rd_data_q : 32'd0;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_bram_responder
// Directed bench for sdram_bram_responder (ADDR_BITS=14, BURST_LEN=8,
// READ_LATENCY=2). Each transaction is traced cycle by cycle relative to its
// cycle 0, and each test task compares the trace against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sdram_bram_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_bram_responder_if bus();

  sdram_bram_responder #(
    .ADDR_BITS(14), .BURST_LEN(8), .READ_LATENCY(2), .INIT_FILE("")
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        tr_ack   [32];
  logic [2:0]  tr_valid [32];
  logic [31:0] tr_data  [32];
  logic        tr_cmp   [32];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c);
    tr_ack[c]   = bus.sdram_ack;
    tr_valid[c] = bus.sdram_rdvalid;
    tr_data[c]  = bus.sdram_rdata;
    tr_cmp[c]   = bus.sdram_complete;
  endtask

  // Presents a command in cycle 0, holds it through the ack cycle, drops it in
  // cycle 2 and traces outputs up to cycle ncyc.
  task automatic run_cmd(input logic [2:0] id, input logic [25:0] addr, input logic wr,
                         input logic bu, input logic [3:0] be, input logic [31:0] wd,
                         input int ncyc);
    sample(0);
    bus.sdram_req = id;  bus.sdram_addr = addr;  bus.sdram_write = wr;
    bus.sdram_burst = bu;  bus.sdram_byte_enable = be;  bus.sdram_wdata = wd;
    for (int c = 1; c <= ncyc; c++) begin
      cyc();
      sample(c);
      if (c == 2) bus.sdram_req = 3'd0;
    end
    $display("txn %s id=%0d addr=%h burst=%0d be=%h wdata=%h", wr ? "write" : "read ",
             id, addr, bu, be, wd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sdram_req = 3'd0; bus.sdram_addr = '0; bus.sdram_write = 1'b0;
    bus.sdram_burst = 1'b0; bus.sdram_byte_enable = 4'h0; bus.sdram_wdata = '0;
    repeat (3) cyc();
    n_checks++; if (bus.sdram_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.sdram_ack); else n_pass++;
    n_checks++; if (bus.sdram_rdvalid !== 3'd0) $display("FAIL reset_rdvalid: got %0d want 0", bus.sdram_rdvalid); else n_pass++;
    n_checks++; if (bus.sdram_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus.sdram_rdata); else n_pass++;
    n_checks++; if (bus.sdram_complete !== 1'b0) $display("FAIL reset_complete: got %b want 0", bus.sdram_complete); else n_pass++;
    rst = 1'b0;
    cyc();
    $display("txn reset released");
  endtask

  task automatic test_single();
    run_cmd(3'd2, 26'h000100, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 2);
    n_checks++; if (tr_ack[0] !== 1'b0) $display("FAIL single_wr_ack_c0: got %b want 0", tr_ack[0]); else n_pass++;
    n_checks++; if (tr_ack[1] !== 1'b1) $display("FAIL single_wr_ack_c1: got %b want 1", tr_ack[1]); else n_pass++;
    n_checks++; if (tr_ack[2] !== 1'b0) $display("FAIL single_wr_ack_c2: got %b want 0", tr_ack[2]); else n_pass++;
    run_cmd(3'd2, 26'h000100, 1'b0, 1'b0, 4'h0, 32'h0, 4);
    n_checks++; if (tr_valid[2] !== 3'd0) $display("FAIL single_rd_early: got %0d want 0", tr_valid[2]); else n_pass++;
    n_checks++; if (tr_valid[3] !== 3'd2) $display("FAIL single_rd_rdvalid: got %0d want 2", tr_valid[3]); else n_pass++;
    n_checks++; if (tr_data[3] !== 32'hDEADBEEF) $display("FAIL single_rd_data: got %h want deadbeef", tr_data[3]); else n_pass++;
    n_checks++; if (tr_cmp[3] !== 1'b1) $display("FAIL single_rd_complete: got %b want 1", tr_cmp[3]); else n_pass++;
    n_checks++; if (tr_valid[4] !== 3'd0 || tr_cmp[4] !== 1'b0 || tr_data[4] !== 32'd0)
      $display("FAIL single_rd_after: got valid=%0d cmp=%b data=%h want 0/0/0", tr_valid[4], tr_cmp[4], tr_data[4]); else n_pass++;
  endtask

  task automatic test_byte_enable();
    run_cmd(3'd1, 26'h000200, 1'b1, 1'b0, 4'hF, 32'h11223344, 2);
    run_cmd(3'd1, 26'h000200, 1'b1, 1'b0, 4'b0101, 32'hAABBCCDD, 2);
    run_cmd(3'd1, 26'h000200, 1'b0, 1'b0, 4'h0, 32'h0, 4);
    n_checks++; if (tr_data[3] !== 32'h11BB33DD) $display("FAIL be_merge: got %h want 11bb33dd", tr_data[3]); else n_pass++;
    run_cmd(3'd4, 26'h000200, 1'b1, 1'b0, 4'h0, 32'hFFFFFFFF, 2);
    n_checks++; if (tr_ack[1] !== 1'b1) $display("FAIL be_zero_ack: got %b want 1", tr_ack[1]); else n_pass++;
    run_cmd(3'd4, 26'h000200, 1'b0, 1'b0, 4'h0, 32'h0, 4);
    n_checks++; if (tr_data[3] !== 32'h11BB33DD) $display("FAIL be_zero_nochange: got %h want 11bb33dd", tr_data[3]); else n_pass++;
    // Bit 16 lies above the word index and aliases onto the same word.
    run_cmd(3'd5, 26'h010200, 1'b0, 1'b0, 4'h0, 32'h0, 4);
    n_checks++; if (tr_valid[3] !== 3'd5 || tr_data[3] !== 32'h11BB33DD)
      $display("FAIL alias_read: got id=%0d data=%h want 5/11bb33dd", tr_valid[3], tr_data[3]); else n_pass++;
  endtask

  task automatic test_burst();
    int acks;
    for (int i = 0; i < 8; i++) run_cmd(3'd1, 26'(4 * i), 1'b1, 1'b0, 4'hF, 32'(i), 2);
    run_cmd(3'd1, 26'h000018, 1'b0, 1'b1, 4'h0, 32'h0, 11);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tr_valid[3+i] !== 3'd1 || tr_data[3+i] !== 32'((6 + i) % 8) || tr_cmp[3+i] !== (i == 7))
        $display("FAIL burst_beat%0d: got id=%0d data=%h cmp=%b want 1/%h/%b",
                 i, tr_valid[3+i], tr_data[3+i], tr_cmp[3+i], 32'((6 + i) % 8), (i == 7));
      else n_pass++;
    end
    n_checks++; if (tr_valid[11] !== 3'd0 || tr_cmp[11] !== 1'b0)
      $display("FAIL burst_after: got id=%0d cmp=%b want 0/0", tr_valid[11], tr_cmp[11]); else n_pass++;
    acks = 0;
    for (int c = 2; c <= 11; c++) if (tr_ack[c] === 1'b1) acks++;
    n_checks++; if (acks != 0) $display("FAIL burst_no_ack: got %0d acks want 0", acks); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acks;
    sample(0);
    bus.sdram_req = 3'd1; bus.sdram_addr = 26'h0; bus.sdram_write = 1'b0;
    bus.sdram_burst = 1'b1; bus.sdram_byte_enable = 4'h0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      sample(c);
      if (c == 2) begin
        bus.sdram_req = 3'd3; bus.sdram_addr = 26'h00001C; bus.sdram_burst = 1'b0;
      end
      if (c == 13) bus.sdram_req = 3'd0;
    end
    $display("txn read  id=1 burst addr=0 then held id=3 single addr=1c");
    acks = 0;
    for (int c = 1; c <= 16; c++) if (tr_ack[c] === 1'b1) acks++;
    n_checks++; if (acks != 2) $display("FAIL b2b_ack_count: got %0d want 2", acks); else n_pass++;
    n_checks++; if (tr_ack[1] !== 1'b1 || tr_ack[12] !== 1'b1)
      $display("FAIL b2b_ack_cycles: got c1=%b c12=%b want 1/1", tr_ack[1], tr_ack[12]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tr_valid[3+i] !== 3'd1 || tr_data[3+i] !== 32'(i))
        $display("FAIL b2b_beat%0d: got id=%0d data=%h want 1/%h", i, tr_valid[3+i], tr_data[3+i], 32'(i));
      else n_pass++;
    end
    n_checks++; if (tr_cmp[10] !== 1'b1) $display("FAIL b2b_last_complete: got %b want 1", tr_cmp[10]); else n_pass++;
    n_checks++; if (tr_valid[13] !== 3'd0) $display("FAIL b2b_gap: got %0d want 0", tr_valid[13]); else n_pass++;
    n_checks++; if (tr_valid[14] !== 3'd3 || tr_data[14] !== 32'd7 || tr_cmp[14] !== 1'b1)
      $display("FAIL b2b_id3_beat: got id=%0d data=%h cmp=%b want 3/7/1", tr_valid[14], tr_data[14], tr_cmp[14]); else n_pass++;
    n_checks++; if (tr_valid[15] !== 3'd0) $display("FAIL b2b_id3_after: got %0d want 0", tr_valid[15]); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    sample(0);
    bus.sdram_req = 3'd1; bus.sdram_addr = 26'h0; bus.sdram_write = 1'b0; bus.sdram_burst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      sample(c);
      if (c == 2) bus.sdram_req = 3'd0;
    end
    n_checks++; if (tr_valid[6] !== 3'd1 || tr_data[6] !== 32'd3)
      $display("FAIL rst_mid_beat3: got id=%0d data=%h want 1/3", tr_valid[6], tr_data[6]); else n_pass++;
    rst = 1'b1;
    cyc();
    sample(7);
    rst = 1'b0;
    $display("txn read  id=1 burst addr=0 reset at beat 3");
    n_checks++; if (tr_valid[7] !== 3'd0 || tr_cmp[7] !== 1'b0 || tr_ack[7] !== 1'b0)
      $display("FAIL rst_mid_after: got id=%0d cmp=%b ack=%b want 0/0/0", tr_valid[7], tr_cmp[7], tr_ack[7]); else n_pass++;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (bus.sdram_rdvalid !== 3'd0 || bus.sdram_complete !== 1'b0 || bus.sdram_ack !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL rst_mid_no_beats: got %0d active cycles want 0", stray); else n_pass++;
    run_cmd(3'd7, 26'h000014, 1'b0, 1'b0, 4'h0, 32'h0, 4);
    n_checks++; if (tr_ack[1] !== 1'b1 || tr_valid[2] !== 3'd0)
      $display("FAIL rst_then_read_timing: got ack=%b c2_id=%0d want 1/0", tr_ack[1], tr_valid[2]); else n_pass++;
    n_checks++; if (tr_valid[3] !== 3'd7 || tr_data[3] !== 32'd5 || tr_cmp[3] !== 1'b1)
      $display("FAIL rst_then_read: got id=%0d data=%h cmp=%b want 7/5/1", tr_valid[3], tr_data[3], tr_cmp[3]); else n_pass++;
  endtask

  task automatic test_idle_hold();
    bus.sdram_req = 3'd0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      n_checks++;
      if (bus.sdram_ack !== 1'b0 || bus.sdram_rdvalid !== 3'd0 || bus.sdram_complete !== 1'b0)
        $display("FAIL idle_hold_c%0d: got ack=%b id=%0d cmp=%b want 0/0/0",
                 c, bus.sdram_ack, bus.sdram_rdvalid, bus.sdram_complete);
      else n_pass++;
    end
    $display("txn idle hold 100 cycles");
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_enable();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_idle_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
